prng_seq_ctrl: RTL and testbench

//  Single-clock controller for the PRNG datapath (16-bit data LFSR, 8-bit control LFSR, 16->8 mux).

---
 rtl/prng_seq_ctrl_if.sv | 19 +
 rtl/prng_seq_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_prng_seq_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/prng_seq_ctrl_if.sv
// rtl/prng_seq_ctrl_if.sv - random byte stream handshake between controller and consumer
// master drives the byte and its valid flag, slave returns ready.
interface prng_seq_ctrl_if;
  logic       rnd_valid;
  logic       rnd_ready;
  logic [7:0] rnd_data;

  modport master (
    output rnd_valid,
    output rnd_data,
    input  rnd_ready
  );

  modport slave (
    input  rnd_valid,
    input  rnd_data,
    output rnd_ready
  );
endinterface

// File: rtl/prng_seq_ctrl.sv
// rtl/prng_seq_ctrl.sv - single-clock sequencer for the LFSR/mux PRNG datapath
// Seeds both LFSRs, warms them up, then offers bytes and refreshes the display byte.
module prng_seq_ctrl #(
  parameter int          CLK_HZ   = 50_000_000,
  parameter int          DISP_HZ  = 1,
  parameter int          CTRL_DIV = 4,
  parameter int          WARMUP   = 16,
  parameter logic [15:0] SEED16   = 16'hACE1,
  parameter logic [7:0]  SEED8    = 8'h5A
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  EN,
  input  logic                  seed_load,
  input  logic [15:0]           seed_in,
  input  logic [7:0]            mux_out,
  output logic                  ld,
  output logic [15:0]           ld_val16,
  output logic [7:0]            ld_val8,
  output logic                  step_data,
  output logic                  step_ctrl,
  prng_seq_ctrl_if.master       rnd,
  output logic                  disp_tick,
  output logic [7:0]            disp_byte,
  output logic                  clk_led
);

  localparam int DIV = CLK_HZ / DISP_HZ;
  localparam int DW  = $clog2(DIV);
  localparam int CW  = (CTRL_DIV > 1) ? $clog2(CTRL_DIV) : 1;
  localparam int WW  = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_WARM,
    S_STEP,
    S_CAPT,
    S_OFFER
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          seed_pend;
  logic          ld_user;
  logic [15:0]   seed_reg;
  logic [WW-1:0] warm_cnt;
  logic [CW-1:0] ctrl_cnt;
  logic [DW-1:0] disp_cnt;

  logic pend_eff;
  logic running;
  logic hs;
  logic warm_done;
  logic ctrl_hit;
  logic disp_hit;

  // A seed_load in the current cycle counts as pending for the transition decision.
  assign pend_eff  = seed_pend | seed_load;
  assign running   = (state == S_STEP) || (state == S_CAPT) || (state == S_OFFER);
  assign hs        = rnd.rnd_valid & rnd.rnd_ready;
  assign warm_done = (warm_cnt == WW'(WARMUP - 1));
  assign ctrl_hit  = (ctrl_cnt == CW'(CTRL_DIV - 1));
  assign disp_hit  = (disp_cnt == DW'(DIV - 1));

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    ld        = 1'b0;
    ld_val16  = 16'h0000;
    ld_val8   = 8'h00;
    step_data = 1'b0;
    step_ctrl = 1'b0;
    disp_tick = 1'b0;
    case (state)
      S_IDLE: begin
        state_nx = S_SEED;
      end
      S_SEED: begin
        ld = 1'b1;
        // An all-ones load would freeze an XNOR LFSR, so fall back to the default seed.
        if (ld_user && (seed_reg != 16'hFFFF)) begin
          ld_val16 = seed_reg;
        end else begin
          ld_val16 = SEED16;
        end
        if (ld_user && (seed_reg[7:0] != 8'hFF)) begin
          ld_val8 = seed_reg[7:0];
        end else begin
          ld_val8 = SEED8;
        end
        state_nx = S_WARM;
      end
      S_WARM: begin
        step_data = 1'b1;
        step_ctrl = 1'b1;
        if (warm_done) begin
          state_nx = pend_eff ? S_SEED : S_STEP;
        end
      end
      S_STEP: begin
        step_data = 1'b1;
        state_nx  = S_CAPT;
      end
      S_CAPT: begin
        state_nx = S_OFFER;
      end
      S_OFFER: begin
        if (hs) begin
          state_nx = S_STEP;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
    if (running) begin
      step_ctrl = ctrl_hit;
      disp_tick = disp_hit;
      if (seed_load) begin
        state_nx = S_SEED;
      end
    end
    if (!EN) begin
      state_nx = S_IDLE;
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      seed_pend     <= 1'b0;
      ld_user       <= 1'b0;
      seed_reg      <= 16'h0000;
      rnd.rnd_valid <= 1'b0;
      rnd.rnd_data  <= 8'h00;
      warm_cnt      <= '0;
      ctrl_cnt      <= '0;
      disp_cnt      <= '0;
    end else if (!EN) begin
      seed_pend     <= 1'b0;
      ld_user       <= 1'b0;
      rnd.rnd_valid <= 1'b0;
      rnd.rnd_data  <= 8'h00;
      warm_cnt      <= '0;
      ctrl_cnt      <= '0;
      disp_cnt      <= '0;
    end else begin
      if (seed_load) begin
        seed_reg <= seed_in;
      end
      // Entering SEED consumes the pending seed and abandons any unconsumed byte.
      if (state_nx == S_SEED) begin
        ld_user       <= pend_eff;
        seed_pend     <= 1'b0;
        rnd.rnd_valid <= 1'b0;
      end else begin
        seed_pend <= pend_eff;
        if (state == S_CAPT) begin
          rnd.rnd_valid <= 1'b1;
          rnd.rnd_data  <= mux_out;
        end else if (hs) begin
          rnd.rnd_valid <= 1'b0;
        end
      end
      if ((state == S_WARM) && !warm_done) begin
        warm_cnt <= warm_cnt + WW'(1);
      end else begin
        warm_cnt <= '0;
      end
      if (running && !ctrl_hit) begin
        ctrl_cnt <= ctrl_cnt + CW'(1);
      end else begin
        ctrl_cnt <= '0;
      end
      if (running && !disp_hit) begin
        disp_cnt <= disp_cnt + DW'(1);
      end else begin
        disp_cnt <= '0;
      end
    end
  end

  // Display state survives EN=0; only rst clears it.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      disp_byte <= 8'h00;
      clk_led   <= 1'b0;
    end else if (disp_tick) begin
      disp_byte <= rnd.rnd_valid ? rnd.rnd_data : mux_out;
      clk_led   <= ~clk_led;
    end
  end

endmodule

// File: tb/tb_prng_seq_ctrl.sv
// tb/tb_prng_seq_ctrl.sv - bench for prng_seq_ctrl with an elapsed-time reference model
// Model tracks cycles since seed and since byte request; directed literals pin it.
module tb_prng_seq_ctrl;
  localparam int          W   = 4;
  localparam int          CD  = 4;
  localparam int          DV  = 8;
  localparam logic [15:0] S16 = 16'hACE1;
  localparam logic [7:0]  S8  = 8'h5A;

  logic        CLK = 1'b0;
  logic        rst;
  logic        EN;
  logic        seed_load;
  logic [15:0] seed_in;
  logic [7:0]  mux_out;
  logic        ld;
  logic [15:0] ld_val16;
  logic [7:0]  ld_val8;
  logic        step_data;
  logic        step_ctrl;
  logic        disp_tick;
  logic [7:0]  disp_byte;
  logic        clk_led;

  prng_seq_ctrl_if rnd_if();

  prng_seq_ctrl #(
    .CLK_HZ(8), .DISP_HZ(1), .CTRL_DIV(CD), .WARMUP(W), .SEED16(S16), .SEED8(S8)
  ) dut (
    .CLK(CLK), .rst(rst), .EN(EN), .seed_load(seed_load), .seed_in(seed_in),
    .mux_out(mux_out), .ld(ld), .ld_val16(ld_val16), .ld_val8(ld_val8),
    .step_data(step_data), .step_ctrl(step_ctrl), .rnd(rnd_if),
    .disp_tick(disp_tick), .disp_byte(disp_byte), .clk_led(clk_led)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_seen  = 0;
  bit mux_rand = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: age = cycles since SEED entry, bage = cycles since byte request.
  bit          m_active;
  int          m_age;
  int          m_bage;
  logic        m_valid;
  logic [7:0]  m_data;
  logic [7:0]  m_disp;
  logic        m_led;
  logic        m_pend;
  logic        m_user;
  logic [15:0] m_preg;
  logic [15:0] m_seed;
  logic        e_ld, e_sd, e_sc, e_tick;
  logic [15:0] e_v16;
  logic [7:0]  e_v8;

  task automatic model_reset();
    m_active = 0; m_age = 0; m_bage = 0; m_valid = 0; m_data = 0;
    m_disp = 0; m_led = 0; m_pend = 0; m_user = 0; m_preg = 0; m_seed = 0;
  endtask

  task automatic model_outputs();
    bit in_seed, in_warm, in_run;
    int ridx;
    in_seed = m_active && (m_age == 0);
    in_warm = m_active && (m_age >= 1) && (m_age <= W);
    in_run  = m_active && (m_age > W);
    ridx    = m_age - W - 1;
    e_ld    = in_seed;
    e_v16   = !in_seed ? 16'h0 : ((!m_user || m_seed == 16'hFFFF) ? S16 : m_seed);
    e_v8    = !in_seed ? 8'h0 : ((!m_user || m_seed[7:0] == 8'hFF) ? S8 : m_seed[7:0]);
    e_sd    = in_warm || (in_run && m_bage == 0);
    e_sc    = in_warm || (in_run && (ridx % CD) == CD - 1);
    e_tick  = in_run && (ridx % DV) == DV - 1;
  endtask

  task automatic enter_seed(input logic user, input logic [15:0] val);
    m_active = 1; m_age = 0; m_user = user; m_seed = val; m_pend = 0; m_valid = 0;
  endtask

  task automatic model_step();
    logic np;
    logic [15:0] nr;
    model_outputs();
    if (e_tick) begin
      m_disp = m_valid ? m_data : mux_out;
      m_led  = ~m_led;
    end
    np = m_pend | seed_load;
    nr = seed_load ? seed_in : m_preg;
    if (!EN) begin
      m_active = 0; m_valid = 0; m_data = 0; m_pend = 0;
    end else begin
      m_preg = nr;
      if (!m_active) enter_seed(np, nr);
      else if (m_age < W) begin m_age++; m_pend = np; end
      else if (m_age == W) begin
        if (np) enter_seed(1'b1, nr);
        else begin m_age++; m_bage = 0; end
      end else if (seed_load) enter_seed(1'b1, nr);
      else begin
        m_age++;
        if (m_bage == 0) m_bage = 1;
        else if (m_bage == 1) begin m_data = mux_out; m_valid = 1; m_bage = 2; end
        else if (rnd_if.rnd_ready) begin m_valid = 0; m_bage = 0; end
      end
    end
  endtask

  always @(posedge CLK) begin
    if (rnd_if.rnd_valid && rnd_if.rnd_ready) hs_seen++;
    if (!rst) model_reset();
    else model_step();
    #1;
    model_outputs();
    chk("m_ld", ld, e_ld);
    chk("m_ld_val16", ld_val16, e_v16);
    chk("m_ld_val8", ld_val8, e_v8);
    chk("m_step_data", step_data, e_sd);
    chk("m_step_ctrl", step_ctrl, e_sc);
    chk("m_disp_tick", disp_tick, e_tick);
    chk("m_rnd_valid", rnd_if.rnd_valid, m_valid);
    chk("m_rnd_data", rnd_if.rnd_data, m_data);
    chk("m_disp_byte", disp_byte, m_disp);
    chk("m_clk_led", clk_led, m_led);
  end

  task automatic next_cyc();
    @(negedge CLK);
    if (mux_rand) mux_out = 8'($urandom);
  endtask

  initial begin
    int sc, sd, tk, lt, same, waited, hs0;
    logic prev_led;
    rst = 0; EN = 0; seed_load = 0; seed_in = 0; mux_out = 0; rnd_if.rnd_ready = 0;
    #1;
    chk("rst_ld", ld, 0);
    chk("rst_valid", rnd_if.rnd_valid, 0);
    chk("rst_ld_val16", ld_val16, 0);
    chk("rst_disp_byte", disp_byte, 0);
    repeat (3) next_cyc();
    rst = 1; EN = 1; mux_out = 8'h3C;
    next_cyc();
    chk("seed1_ld", ld, 1);
    chk("seed1_v16", ld_val16, 16'hACE1);
    chk("seed1_v8", ld_val8, 8'h5A);
    sd = 0;
    for (int i = 0; i < 4; i++) begin next_cyc(); sd += int'(step_data); end
    chk("warm_steps", sd, 4);
    next_cyc(); next_cyc();
    chk("valid_c7", rnd_if.rnd_valid, 0);
    next_cyc();
    chk("valid_c8", rnd_if.rnd_valid, 1);
    chk("data_c8", rnd_if.rnd_data, 8'h3C);

    mux_rand = 1;
    sc = 0; sd = 0; same = 0;
    for (int i = 0; i < 20; i++) begin
      next_cyc();
      sc += int'(step_ctrl);
      sd += int'(step_data);
      if (rnd_if.rnd_valid && rnd_if.rnd_data == 8'h3C) same++;
    end
    chk("hold_step_ctrl_pulses", sc, 5);
    chk("hold_step_data", sd, 0);
    chk("hold_data_stable", same, 20);

    rnd_if.rnd_ready = 1;
    hs0 = hs_seen; tk = 0; lt = 0; prev_led = clk_led;
    for (int i = 0; i < 24; i++) begin
      next_cyc();
      tk += int'(disp_tick);
      if (clk_led != prev_led) lt++;
      prev_led = clk_led;
    end
    rnd_if.rnd_ready = 0;
    chk("stream_handshakes", hs_seen - hs0, 8);
    chk("stream_disp_ticks", tk, 3);
    chk("stream_led_toggles", lt, 3);

    for (waited = 0; waited < 6 && !rnd_if.rnd_valid; waited++) next_cyc();
    chk("offer_before_reseed", rnd_if.rnd_valid, 1);
    seed_load = 1; seed_in = 16'hFFFF;
    next_cyc();
    seed_load = 0;
    chk("ffff_valid_drop", rnd_if.rnd_valid, 0);
    chk("ffff_ld", ld, 1);
    chk("ffff_v16", ld_val16, 16'hACE1);
    chk("ffff_v8", ld_val8, 8'h5A);
    next_cyc();
    seed_load = 1; seed_in = 16'h1234;
    next_cyc();
    seed_load = 0;
    for (waited = 0; waited < 8 && !ld; waited++) next_cyc();
    chk("warm_reseed_delay", waited, 3);
    chk("user_v16", ld_val16, 16'h1234);
    chk("user_v8", ld_val8, 8'h34);

    next_cyc(); next_cyc();
    EN = 0;
    next_cyc();
    chk("en0_ld", ld, 0);
    chk("en0_step_data", step_data, 0);
    chk("en0_step_ctrl", step_ctrl, 0);
    EN = 1;
    next_cyc();
    chk("reen_ld", ld, 1);
    chk("reen_v16", ld_val16, 16'hACE1);
    chk("reen_v8", ld_val8, 8'h5A);

    for (waited = 0; waited < 12 && !rnd_if.rnd_valid; waited++) next_cyc();
    chk("valid_before_rst", rnd_if.rnd_valid, 1);
    hs0 = hs_seen;
    rnd_if.rnd_ready = 1;
    #2 rst = 0;
    #1;
    chk("arst_valid", rnd_if.rnd_valid, 0);
    chk("arst_data", rnd_if.rnd_data, 0);
    chk("arst_disp_byte", disp_byte, 0);
    chk("arst_clk_led", clk_led, 0);
    chk("arst_step_data", step_data, 0);
    repeat (3) next_cyc();
    chk("arst_no_handshake", hs_seen - hs0, 0);
    rst = 1; rnd_if.rnd_ready = 0;
    for (int i = 0; i < 40; i++) begin
      next_cyc();
      rnd_if.rnd_ready = 1'($urandom_range(0, 1));
    end
    next_cyc();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
